// File: rtl/enc_neuron_seq.sv
// enc_neuron_seq: sequential fixed-point neuron.
// Accepts N_IN signed activations one per beat, multiply-accumulates them
// against the parallel weight vector, adds the bias, then emits the
// (optionally ReLU'd) result on a valid/ready output.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous flush back to IDLE (drops any beat)
//   relu_en               zero negative results
//   w_flat                N_IN weights, w[i] = w_flat[i*DATA_WIDTH +: DATA_WIDTH]
//   bias                  bias in the same Q format as activations
//   in_valid/in_ready     activation handshake, in_data one activation per beat
//   out_valid/out_ready   result handshake, out_data held until accepted
//   busy                  high whenever the FSM is not IDLE
//
// Build option: ENC_NEURON_SAT_EN saturates the shifted result to the
// DATA_WIDTH signed range; without it the result wraps (low bits kept).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for first activation (idx = 0)
// ACC   | accumulating activations 1..N_IN-1
// BIAS  | one cycle: add bias, register result
// OUT   | result presented until out_ready

module enc_neuron_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int N_IN       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       relu_en,
    input  logic [N_IN*DATA_WIDTH-1:0] w_flat,
    input  logic [DATA_WIDTH-1:0]      bias,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       busy
);

    localparam int AW = 2*DATA_WIDTH + $clog2(N_IN);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_IN - 1);
    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    alive_q;

    logic signed [DATA_WIDTH-1:0]   w_arr [N_IN];
    logic signed [2*DATA_WIDTH-1:0] x_ext, w_ext, prod;
    logic signed [AW-1:0]           prod_ext, bias_sh, acc_bias, shifted;
    logic [DATA_WIDTH-1:0]          result;
    logic                           beat;

    for (genvar i = 0; i < N_IN; i++) begin : g_w
        assign w_arr[i] = w_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // idx_q is 0 in IDLE, so one weight mux serves both IDLE and ACC
    assign x_ext    = {{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
    assign w_ext    = {{DATA_WIDTH{w_arr[idx_q][DATA_WIDTH-1]}}, w_arr[idx_q]};
    assign prod     = x_ext * w_ext;
    assign prod_ext = AW'(prod);
    assign bias_sh  = AW'($signed(bias)) <<< FRAC_BITS;
    assign acc_bias = acc_q + bias_sh;
    assign shifted  = acc_bias >>> FRAC_BITS;

    always_comb begin
        result = shifted[DATA_WIDTH-1:0];
`ifdef ENC_NEURON_SAT_EN
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_WIDTH-1:0];
        end
`endif
        if (relu_en && result[DATA_WIDTH-1]) begin
            result = '0;
        end
    end

    // alive_q keeps in_ready low while reset is asserted
    assign in_ready  = alive_q && ((state_q == S_IDLE) || (state_q == S_ACC));
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign beat      = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    acc_d = prod_ext;
                    if (N_IN == 1) begin
                        state_d = S_BIAS;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (beat) begin
                    acc_d = acc_q + prod_ext;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_BIAS;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_BIAS: begin
                acc_d      = acc_bias;
                out_data_d = result;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            alive_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_enc_neuron_seq.sv
module tb_enc_neuron_seq;

    localparam int DW = 16;
    localparam int FB = 8;
    localparam int N  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic            relu_en;
    logic [N*DW-1:0] w_flat;
    logic [DW-1:0]   bias;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            busy;

    enc_neuron_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .N_IN(N)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .relu_en(relu_en),
        .w_flat(w_flat), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_pushed = 0;
    int            n_popped = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] xv[N];
    logic [DW-1:0] wv[N];
    bit            rdy_auto = 1'b1;
    bit            rdy_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer dot product, bias scaled into the same
    // fixed-point grid, floor division by 2^FB, then range reduction.
    function automatic logic [DW-1:0] ref_out(input bit relu);
        longint s = 0;
        longint sh;
        logic [63:0] shv;
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++)
            s += longint'($signed(xv[i])) * longint'($signed(wv[i]));
        s += longint'($signed(bias)) * (longint'(1) << FB);
        sh = s >>> FB;
        shv = sh;
        r = shv[DW-1:0];
`ifdef ENC_NEURON_SAT_EN
        if (sh > 32767) r = 16'h7fff;
        else if (sh < -32768) r = 16'h8000;
`endif
        if (relu && r[DW-1]) r = '0;
        return r;
    endfunction

    task automatic load_w();
        for (int i = 0; i < N; i++) w_flat[i*DW +: DW] = wv[i];
    endtask

    task automatic fill(input logic [DW-1:0] x, input logic [DW-1:0] w);
        for (int i = 0; i < N; i++) begin
            xv[i] = x;
            wv[i] = w;
        end
        load_w();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int maxg);
        repeat ($urandom_range(maxg, 0)) step();
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("beat_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_vector(input int maxg);
        for (int i = 0; i < N; i++) begin
            send_beat(xv[i]);
            if (i < N-1) gap(maxg);
        end
        @(negedge clk);
        chk("lat_bias_cycle_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout_busy", busy, 0);
        step();
    endtask

    task automatic run_vector(input logic [DW-1:0] exp, input int maxg);
        sb_q.push_back(exp);
        n_pushed++;
        send_vector(maxg);
        wait_idle();
    endtask

    // Scoreboard monitor: pops one expected result per output handshake.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", out_data, 32'hdead_beef);
                end else begin
                    e = sb_q.pop_front();
                    n_popped++;
                    chk("out_data", out_data, e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_auto) out_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; relu_en = 1'b0; bias = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; w_flat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        step();
        rst_n = 1'b1;
        step(); step();
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        step();

        // unity weights, unity activations -> 16.0
        fill(16'h0100, 16'h0100); bias = 16'h0000; relu_en = 1'b0;
        run_vector(16'h1000, 0);

        // negative sum plus bias, with and without ReLU
        fill(16'h0100, 16'hff00); bias = 16'h0033; relu_en = 1'b0;
        run_vector(16'hf033, 2);
        relu_en = 1'b1;
        run_vector(16'h0000, 2);
        relu_en = 1'b0;

        // overflow: wraps by default, saturates with the build option
        fill(16'h7fff, 16'h7fff); bias = 16'h0000;
`ifdef ENC_NEURON_SAT_EN
        run_vector(16'h7fff, 1);
`else
        run_vector(16'hf000, 1);
`endif

        // output backpressure for 5 cycles while offering a beat
        fill(16'h0100, 16'h0100); bias = 16'h0000;
        rdy_auto = 1'b0; out_ready = 1'b0;
        sb_q.push_back(16'h1000); n_pushed++;
        send_vector(0);
        in_valid = 1'b1; in_data = 16'h0100;
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, 16'h1000);
            chk("hold_in_ready", in_ready, 0);
        end
        step();
        in_valid = 1'b0; out_ready = 1'b1; rdy_auto = 1'b1;
        wait_idle();

        // clear after 7 beats, with a beat offered in the clear cycle
        for (int i = 0; i < 7; i++) send_beat(16'h0100);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h0100;
        step();
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clear_busy", busy, 0);
        chk("clear_out_valid", out_valid, 0);
        step();
        run_vector(16'h1000, 0);

        // reset mid-accumulation with input gaps
        for (int i = 0; i < 10; i++) begin
            send_beat(16'h0100);
            gap(2);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", out_data, 0);
        step(); step();
        rst_n = 1'b1;
        step(); step();
        run_vector(16'h1000, 1);

        // randomized vectors under random output backpressure
        rdy_rand = 1'b1;
        for (int v = 0; v < 24; v++) begin
            for (int i = 0; i < N; i++) begin
                xv[i] = DW'($urandom);
                wv[i] = (v < 8) ? DW'($urandom_range(1023, 0) - 512) : DW'($urandom);
            end
            load_w();
            bias    = DW'($urandom);
            relu_en = 1'($urandom_range(1, 0));
            run_vector(ref_out(relu_en), 3);
        end
        rdy_rand = 1'b0;

        begin
            int k = 0;
            while (sb_q.size() != 0 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("result_count", n_popped, n_pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
